aesl_axis_stall_detector: RTL
=============================

Name: aesl_axis_stall_detector

Overview:
- Per-channel AXI-Stream stall detector for the cosim deadlock-monitor tree.
- Watches the tvalid/tready pair of each top-level AXIS port and raises `axis_block_sigs[i]` after THRESH consecutive stalled cycles.
- Producer end of the `axis_block_sigs` bus consumed by the AESL deadlock monitors. Instantiated once per top-level DUT in the cosim wrapper.

Parameters:
- NUM_CH, 2: number of AXIS channels monitored.
- THRESH, 16: consecutive stall cycles before a channel is flagged. Legal range 1..65535.
- CNT_W, $clog2(THRESH+1): stall counter width. Derived; not overridden.
- IS_INPUT, 2'b01: bit i = 1 means channel i is a DUT input port (DUT is the consumer); 0 means a DUT output port (DUT is the producer).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- monitor_en  in  1  detection enable. 0 forces all channels to IDLE.
- ch_tvalid  in  NUM_CH  tvalid of each monitored channel.
- ch_tready  in  NUM_CH  tready of each monitored channel.
- inst_idle  in  1  DUT top idle. A stall while idle is not a block.
- axis_block_sigs  out  NUM_CH  per-channel blocked flag, registered.
- any_block  out  1  OR of axis_block_sigs, registered.
- block_onehot_first  out  NUM_CH  one-hot of the lowest-index channel that entered BLOCKED this cycle, registered, single-cycle pulse.

Behaviour:
- Reset (sync, active-high): all outputs 0; all channel FSMs in IDLE; all counters 0.
- Stall condition per channel i, stall_i:
  - input port: ch_tready[i] & ~ch_tvalid[i] (DUT waiting for data).
  - output port: ch_tvalid[i] & ~ch_tready[i] (DUT waiting for space).
  - In both cases also gated by monitor_en & ~inst_idle.
- A handshake (tvalid & tready) is never a stall and clears the channel the same edge.
- Per-channel FSM with states IDLE, WAIT, BLOCKED:
  - IDLE: counter = 0. If stall_i, go to WAIT with counter = 1. If THRESH == 1, go directly to BLOCKED.
  - WAIT: if ~stall_i, go to IDLE with counter = 0. Else counter++. When counter + 1 == THRESH, go to BLOCKED.
  - BLOCKED: counter holds at THRESH (saturates, never wraps). If ~stall_i, go to IDLE with counter = 0.
- `axis_block_sigs[i]` = (state == BLOCKED), registered.
  - Rises on the edge that ends the THRESH-th consecutive stall cycle, so it is visible in cycle THRESH+1 relative to the first stall cycle.
  - Falls on the edge ending the first non-stall cycle (one-cycle latency).
- `any_block` is computed from the next-state values, so it is cycle-aligned with `axis_block_sigs`.
- `block_onehot_first`:
  - Set for one cycle when one or more channels transition into BLOCKED on the same edge.
  - Only the lowest index is reported.
  - Zero otherwise, including while a channel remains in BLOCKED.
- monitor_en deasserted or inst_idle asserted mid-count: the next edge returns that channel to IDLE and clears its counter. There is no hysteresis.
- Simultaneous events: channels are fully independent. One channel clearing does not affect another.
- Reset asserted mid-BLOCKED: outputs are 0 on the cycle after the reset edge.

Optional Feature:
- Macro: AESL_STALL_STATS_EN.
- Defined:
  - Adds output `stall_max` of width NUM_CH*16. Slice i holds the longest run of consecutive stall cycles seen on channel i, saturating at 16'hFFFF.
  - Each slice updates on the edge the run ends and is cleared by reset.
  - Run length counts beyond THRESH through a separate 16-bit counter.
- Undefined: the port is absent, with no extra registers. All other behaviour is identical.

Decomposition:
- Shared package aesl_deadlock_pkg holds:
  - `stall_state_t` enum: IDLE = 2'd0, WAIT = 2'd1, BLOCKED = 2'd2.
  - The default THRESH constant AESL_STALL_THRESH_DEF = 16.
  - Function stall_cond(dir, tvalid, tready).
- One natural sub-module, aesl_axis_stall_ch: single-channel FSM plus counter (and the stats counter under the macro). Generated NUM_CH times.
- The top adds the any_block OR and the priority encoder for block_onehot_first.

Test Plan:
- Reset hold: reset=1 for 3 cycles with ch0 stalled → all outputs 0. After release with the stall held, axis_block_sigs=2'b01 in cycle 17 post-release (THRESH=16).
- Input ch0 (tready=1, tvalid=0) for exactly 15 cycles, then tvalid=1 → axis_block_sigs[0] never rises; counter returns to 0.
- Output ch1 (tvalid=1, tready=0) for 20 cycles → axis_block_sigs=2'b10 from cycle 17 through cycle 21 with block_onehot_first=2'b10 for 1 cycle only. Then tready=1 → flag drops the next cycle.
- Both channels begin stalling on the same cycle → both flags rise together, block_onehot_first=2'b01, any_block=1.
- ch0 stalled 10 cycles, then inst_idle=1 for 1 cycle, then stalled again → flag asserts only 16 stall cycles after the idle cycle. Repeat the scenario with monitor_en=0 substituted for the idle pulse.
- AESL_STALL_STATS_EN defined: stall runs of 5, 40 and 12 cycles on ch0 → stall_max[15:0]=40 afterwards. Reset → 0.

Source files
------------

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the AESL deadlock-monitor tree: channel FSM
// state encoding, default stall threshold and the per-direction stall test.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BLOCKED = 2'd2
  } stall_state_t;

  localparam int AESL_STALL_THRESH_DEF = 16;

  // dir = 1: DUT consumes (starved when ready without valid).
  // dir = 0: DUT produces (back-pressured when valid without ready).
  function automatic logic stall_cond(input logic dir, input logic tvalid,
                                      input logic tready);
    return dir ? (tready & ~tvalid) : (tvalid & ~tready);
  endfunction

endpackage

// File: rtl/aesl_axis_stall_ch.sv
// Single-channel AXIS stall FSM with saturating stall counter.
// With AESL_STALL_STATS_EN defined it also tracks the longest stall run.
module aesl_axis_stall_ch
  import aesl_deadlock_pkg::*;
#(
  parameter int   THRESH = AESL_STALL_THRESH_DEF,
  parameter logic IS_IN  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        tvalid,
  input  logic        tready,
  output logic        blocked,
  output logic        blocked_next
`ifdef AESL_STALL_STATS_EN
  ,
  output logic [15:0] stall_max
`endif
);

  localparam int CNT_W = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  stall_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  always_comb begin
    stall   = en & stall_cond(IS_IN, tvalid, tready);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (stall) begin
          cnt_d   = CNT_W'(1);
          state_d = (THRESH == 1) ? BLOCKED : WAIT;
        end
      end
      WAIT: begin
        if (!stall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == THRESH_C) state_d = BLOCKED;
        end
      end
      BLOCKED: begin
        // Counter parks at THRESH instead of wrapping while the stall persists.
        if (!stall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = THRESH_C;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign blocked      = (state_q == BLOCKED);
  assign blocked_next = (state_d == BLOCKED);

`ifdef AESL_STALL_STATS_EN
  logic [15:0] run_q, run_d;
  logic [15:0] max_q, max_d;

  // Run length is independent of THRESH so long stalls are measured fully.
  always_comb begin
    run_d = run_q;
    max_d = max_q;
    if (stall) begin
      if (run_q != 16'hFFFF) run_d = run_q + 16'd1;
    end else begin
      if (run_q > max_q) max_d = run_q;
      run_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= '0;
      max_q <= '0;
    end else begin
      run_q <= run_d;
      max_q <= max_d;
    end
  end

  assign stall_max = max_q;
`endif

endmodule

// File: rtl/aesl_axis_stall_detector.sv
// Per-channel AXIS stall detector feeding the AESL deadlock monitors.
// Optional macro AESL_STALL_STATS_EN adds the stall_max run-length port.
module aesl_axis_stall_detector
  import aesl_deadlock_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                THRESH   = AESL_STALL_THRESH_DEF,
  parameter logic [NUM_CH-1:0] IS_INPUT = 2'b01
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   monitor_en,
  input  logic [NUM_CH-1:0]      ch_tvalid,
  input  logic [NUM_CH-1:0]      ch_tready,
  input  logic                   inst_idle,
  output logic [NUM_CH-1:0]      axis_block_sigs,
  output logic                   any_block,
  output logic [NUM_CH-1:0]      block_onehot_first
`ifdef AESL_STALL_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]   stall_max
`endif
);

  logic              en;
  logic [NUM_CH-1:0] blocked_next;
  logic [NUM_CH-1:0] enter;
  logic              any_block_q, any_block_d;
  logic [NUM_CH-1:0] onehot_q, onehot_d;

  assign en = monitor_en & ~inst_idle;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    aesl_axis_stall_ch #(
      .THRESH (THRESH),
      .IS_IN  (IS_INPUT[g])
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .en           (en),
      .tvalid       (ch_tvalid[g]),
      .tready       (ch_tready[g]),
      .blocked      (axis_block_sigs[g]),
      .blocked_next (blocked_next[g])
`ifdef AESL_STALL_STATS_EN
      ,
      .stall_max    (stall_max[g*16 +: 16])
`endif
    );
  end

  // Isolating the lowest set bit of the entry vector gives the priority pick.
  always_comb begin
    enter       = blocked_next & ~axis_block_sigs;
    onehot_d    = enter & (~enter + NUM_CH'(1));
    any_block_d = |blocked_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      any_block_q <= 1'b0;
      onehot_q    <= '0;
    end else begin
      any_block_q <= any_block_d;
      onehot_q    <= onehot_d;
    end
  end

  assign any_block          = any_block_q;
  assign block_onehot_first = onehot_q;

endmodule
